// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one synchronous single-port memory between the program
//               loader (L), data path (D) and instruction fetch (I), with a
//               starvation counter that promotes fetch over L and D.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          l_req,
    input  logic          d_req,
    input  logic          i_req,
    input  logic          l_we,
    input  logic          d_we,
    input  logic          l_byte,
    input  logic          d_byte,
    input  logic [AW-1:0] l_addr,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   l_wdata,
    input  logic [31:0]   d_wdata,
    output logic          l_ack,
    output logic          d_ack,
    output logic          i_ack,
    output logic [31:0]   rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic [1:0]    owner
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ISSUE  = 2'd1;
    localparam logic [1:0] c_RDWAIT = 2'd2;

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_L    = 2'd1;
    localparam logic [1:0] c_OWN_D    = 2'd2;
    localparam logic [1:0] c_OWN_I    = 2'd3;

    localparam int              c_SW         = $clog2(STARVE_MAX + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [1:0]      r_owner;
    logic [1:0]      w_winner;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic            r_byte;
    logic [31:0]     r_wdata;
    logic [c_SW-1:0] r_starve;
    logic            w_ack;
    logic [7:0]      w_rbyte;

    // Fetch jumps the queue once it has lost STARVE_MAX arbitrations in a row.
    always_comb begin
        w_winner = c_OWN_NONE;
        if (i_req && (r_starve == c_STARVE_MAX)) w_winner = c_OWN_I;
        else if (l_req)                          w_winner = c_OWN_L;
        else if (d_req)                          w_winner = c_OWN_D;
        else if (i_req)                          w_winner = c_OWN_I;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (w_winner != c_OWN_NONE) w_next_state = c_ISSUE;
            c_ISSUE:  w_next_state = r_we ? c_IDLE : c_RDWAIT;
            c_RDWAIT: w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // Grant-time capture of the winner's request; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner  <= c_OWN_NONE;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_byte   <= 1'b0;
            r_wdata  <= '0;
            r_starve <= '0;
        end else if (r_state == c_IDLE) begin
            if (w_winner != c_OWN_NONE) r_owner <= w_winner;
            case (w_winner)
                c_OWN_L: begin
                    r_addr  <= l_addr;
                    r_we    <= l_we;
                    r_byte  <= l_byte;
                    r_wdata <= l_wdata;
                end
                c_OWN_D: begin
                    r_addr  <= d_addr;
                    r_we    <= d_we;
                    r_byte  <= d_byte;
                    r_wdata <= d_wdata;
                end
                c_OWN_I: begin
                    r_addr  <= i_addr;
                    r_we    <= 1'b0;
                    r_byte  <= 1'b0;
                    r_wdata <= '0;
                end
                default: ;
            endcase
            if (w_winner == c_OWN_I)
                r_starve <= '0;
            else if (i_req && (r_starve != c_STARVE_MAX))
                r_starve <= r_starve + 1'b1;
        end
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_rbyte = mem_rdata[7:0];
            2'd1:    w_rbyte = mem_rdata[15:8];
            2'd2:    w_rbyte = mem_rdata[23:16];
            default: w_rbyte = mem_rdata[31:24];
        endcase
    end

    always_comb begin
        busy   = (r_state != c_IDLE);
        owner  = busy ? r_owner : c_OWN_NONE;
        mem_en = (r_state == c_ISSUE);
        mem_we = mem_en && r_we;
        mem_be = 4'h0;
        if (mem_en) mem_be = r_byte ? (4'b0001 << r_addr[1:0]) : 4'hF;
        // Stores complete in ISSUE, loads one cycle later in RDWAIT.
        w_ack  = (mem_en && r_we) || (r_state == c_RDWAIT);
        l_ack  = w_ack && (r_owner == c_OWN_L);
        d_ack  = w_ack && (r_owner == c_OWN_D);
        i_ack  = w_ack && (r_owner == c_OWN_I);
        rdata  = '0;
        if (r_state == c_RDWAIT) rdata = r_byte ? {24'h0, w_rbyte} : mem_rdata;
    end

    assign mem_addr  = r_addr[AW-1:2];
    assign mem_wdata = r_byte ? {4{r_wdata[7:0]}} : r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Randomised scoreboard bench for mem_arbiter with a transaction
//               level reference model and a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          l_ack, d_ack, i_ack, mem_en, mem_we, busy;
    logic [31:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-3:0] mem_addr;
    logic [3:0]    mem_be;
    logic [1:0]    owner;

    bit            rq [4];
    bit            wq [4];
    bit            bq [4];
    logic [AW-1:0] aq [4];
    logic [31:0]   dq [4];

    mem_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .l_req(rq[1]), .d_req(rq[2]), .i_req(rq[3]),
        .l_we(wq[1]), .d_we(wq[2]), .l_byte(bq[1]), .d_byte(bq[2]),
        .l_addr(aq[1]), .d_addr(aq[2]), .i_addr(aq[3]),
        .l_wdata(dq[1]), .d_wdata(dq[2]),
        .l_ack(l_ack), .d_ack(d_ack), .i_ack(i_ack), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory reacts to the DUT; the model keeps its own copy.
    logic [31:0] emem [16];
    logic [31:0] mmem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) emem[mem_addr[3:0]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                mem_rdata = emem[mem_addr[3:0]];
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    typedef struct {
        int            own;
        bit            we;
        logic [AW-3:0] maddr;
        logic [3:0]    be;
        logic [31:0]   wd;
        logic [31:0]   rd;
        int            issue_cyc;
        int            ack_cyc;
    } exp_t;
    exp_t q[$];

    int  starve   = 0;
    int  free_cyc = 0;
    int  ackc  [4];
    bit  outst [4];
    bit  rand_on, heavy, drop_mode, release_pending;
    bit            st_v [4];
    bit            st_w [4];
    bit            st_b [4];
    logic [AW-1:0] st_a [4];
    logic [31:0]   st_d [4];

    // Transaction-level model: one grant per free cycle, fixed latencies.
    task automatic model_cycle();
        int w, idx, lane;
        logic [31:0] word;
        exp_t e;
        if (!rst || cyc < free_cyc) return;
        w = 0;
        if (rq[3] && starve == SMAX) w = 3;
        else if (rq[1]) w = 1;
        else if (rq[2]) w = 2;
        else if (rq[3]) w = 3;
        if (w == 0) return;
        if (w == 3) starve = 0;
        else if (rq[3] && starve < SMAX) starve++;
        idx  = int'(aq[w][5:2]);
        lane = int'(aq[w][1:0]);
        e.own       = w;
        e.we        = wq[w];
        e.maddr     = aq[w][AW-1:2];
        e.be        = bq[w] ? (4'b0001 << lane) : 4'hF;
        e.wd        = bq[w] ? {4{dq[w][7:0]}} : dq[w];
        e.issue_cyc = cyc + 1;
        word = mmem[idx];
        if (e.we) begin
            for (int b = 0; b < 4; b++) if (e.be[b]) word[8*b +: 8] = e.wd[8*b +: 8];
            mmem[idx] = word;
            e.rd      = '0;
            e.ack_cyc = cyc + 1;
            free_cyc  = cyc + 2;
        end else begin
            e.rd      = bq[w] ? ((word >> (8*lane)) & 32'hFF) : word;
            e.ack_cyc = cyc + 2;
            free_cyc  = cyc + 3;
        end
        q.push_back(e);
        outst[w] = 1'b1;
        ackc[w]  = e.ack_cyc;
    endtask

    task automatic new_req(int k);
        rq[k] = 1'b1;
        aq[k] = $urandom;
        dq[k] = $urandom;
        wq[k] = (k == 3) ? 1'b0 : 1'($urandom_range(0, 1));
        bq[k] = (k == 3) ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic agent(int k);
        if (outst[k]) begin
            if (cyc >= ackc[k]) begin
                outst[k] = 1'b0;
                rq[k]    = 1'b0;
                if (rand_on && ((heavy && k != 1) || $urandom_range(0, 1) == 0)) new_req(k);
            end else if (rand_on) begin
                if ($urandom_range(0, 3) == 0) rq[k] = 1'b0;
                aq[k] = $urandom;
                dq[k] = $urandom;
            end else if (drop_mode) begin
                rq[k] = 1'b0;
            end
        end else if (!rq[k] && rand_on && ((heavy && k != 1) || $urandom_range(0, 5) == 0)) begin
            new_req(k);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (release_pending) begin
            rst = 1'b1;
            free_cyc = cyc;
            starve = 0;
            release_pending = 1'b0;
        end
        for (int k = 1; k < 4; k++) begin
            agent(k);
            if (st_v[k]) begin
                rq[k] = 1'b1; wq[k] = st_w[k]; bq[k] = st_b[k];
                aq[k] = st_a[k]; dq[k] = st_d[k]; st_v[k] = 1'b0;
            end
        end
        model_cycle();
    endtask

    task automatic stage(int k, bit we, bit by, logic [AW-1:0] a, logic [31:0] d);
        st_v[k] = 1'b1; st_w[k] = we; st_b[k] = by; st_a[k] = a; st_d[k] = d;
    endtask

    task automatic drain();
        int n;
        n = 0;
        step();
        while ((rq[1] || rq[2] || rq[3] || outst[1] || outst[2] || outst[3] ||
                cyc < free_cyc) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 1, 0);
    endtask

    initial begin : monitor
        exp_t e;
        int   nacks, who;
        bit   exp_issue, exp_ack, exp_busy;
        forever begin
            @(negedge clk);
            if (!rst) continue;
            exp_issue = (q.size() > 0) && (cyc == q[0].issue_cyc);
            exp_ack   = (q.size() > 0) && (cyc == q[0].ack_cyc);
            exp_busy  = (q.size() > 0) && (cyc >= q[0].issue_cyc);
            chk("busy", busy, exp_busy);
            chk("mem_en", mem_en, exp_issue);
            if (exp_issue) begin
                e = q[0];
                chk("issue_owner", owner, e.own);
                chk("mem_we", mem_we, e.we);
                chk("mem_addr", mem_addr, e.maddr);
                chk("mem_be", mem_be, e.be);
                if (e.we) chk("mem_wdata", mem_wdata, e.wd);
            end else begin
                chk("mem_we_idle", mem_we, 0);
            end
            if (!exp_busy) chk("owner_idle", owner, 0);
            nacks = int'(l_ack) + int'(d_ack) + int'(i_ack);
            if (exp_ack) begin
                e   = q.pop_front();
                who = l_ack ? 1 : d_ack ? 2 : i_ack ? 3 : 0;
                chk("ack_count", nacks, 1);
                chk("ack_owner", who, e.own);
                chk("ack_owner_out", owner, e.own);
                if (!e.we) chk("rdata", rdata, e.rd);
            end else begin
                chk("ack_spurious", nacks, 0);
                chk("rdata_idle", rdata, 0);
            end
        end
    end

    initial begin : stimulus
        for (int k = 0; k < 4; k++) begin
            aq[k] = '0; dq[k] = '0; st_a[k] = '0; st_d[k] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            emem[i] = $urandom;
            mmem[i] = emem[i];
        end
        emem[4]   = 32'hDEADBEEF;
        mmem[4]   = 32'hDEADBEEF;
        mem_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_l_ack", l_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);

        release_pending = 1'b1;
        stage(2, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
        drain();
        stage(2, 1'b1, 1'b1, 32'h0000_0013, 32'h0000_00A5);
        drain();
        emem[4] = 32'h7F00_0000;
        mmem[4] = 32'h7F00_0000;
        stage(2, 1'b0, 1'b1, 32'h0000_0013, 32'h0);
        drain();

        stage(1, 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678);
        stage(2, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
        stage(3, 1'b0, 1'b0, 32'h0000_0048, 32'h0);
        drain();

        // Abort an I load in RDWAIT; the held request must be served after release.
        stage(3, 1'b0, 1'b0, 32'h0000_0024, 32'h0);
        step();
        step();
        @(posedge clk);
        #2;
        rst = 1'b0;
        q.delete();
        outst[3] = 1'b0;
        #1;
        chk("abort_i_ack", i_ack, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_owner", owner, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rdata", rdata, 0);
        step();
        release_pending = 1'b1;
        drain();

        drop_mode = 1'b1;
        stage(2, 1'b0, 1'b0, 32'h0000_0008, 32'h0);
        drain();
        drop_mode = 1'b0;
        repeat (3) begin
            step();
            chk("post_drop_busy", busy, 0);
            chk("post_drop_owner", owner, 0);
        end

        rand_on = 1'b1;
        heavy   = 1'b1;
        repeat (400) step();
        heavy = 1'b0;
        repeat (1500) step();
        rand_on = 1'b0;
        drain();
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
